// File: rtl/ram_dp_be_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package ram_dp_be_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_DATA_W = 1024;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / BYTE_W;

  // Operates on the widest supported word; callers zero-extend and truncate to their width.
  function automatic logic [MAX_DATA_W-1:0] merge_bytes(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int unsigned k = 0; k < MAX_BE_W; k++) begin
      if (be[k]) res[BYTE_W*k +: BYTE_W] = new_w[BYTE_W*k +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_dp_be_clr.sv
// Clear sequencer: walks every word address once, driving a zero-write, after reset or on request.
module ram_dp_be_clr
  import ram_dp_be_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= READY;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte enables, write-first bypass and a zero-fill sequencer.
// Define RAM_DP_BE_OUTREG_EN to add an output register stage (read latency 2).
module ram_dp_be
  import ram_dp_be_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_ok;
  logic              rd_in_rng;
  logic [DATA_W-1:0] wr_word;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_valid_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  ram_dp_be_clr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    wr_ok     = !busy && wr_en && (32'(wr_addr) < DEPTH);
    rd_in_rng = 32'(rd_addr) < DEPTH;
    wr_word   = DATA_W'(merge_bytes(MAX_DATA_W'(mem_q[wr_addr[IDX_W-1:0]]),
                                    MAX_DATA_W'(wr_data),
                                    MAX_BE_W'(wr_be)));
    // The clear sequencer owns the write port while busy.
    mem_we    = busy ? clr_we : wr_ok;
    mem_widx  = busy ? clr_addr[IDX_W-1:0] : wr_addr[IDX_W-1:0];
    mem_wdata = busy ? '0 : wr_word;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_comb begin
    rd_valid_d = !busy && rd_en;
    rd_data_d  = '0;
    if (rd_valid_d && rd_in_rng) begin
      // Same-address write in this cycle: return the merged word (write-first).
      rd_data_d = (wr_ok && (wr_addr == rd_addr)) ? wr_word : mem_q[rd_addr[IDX_W-1:0]];
    end
  end

`ifdef RAM_DP_BE_OUTREG_EN
  logic              clr_acc;
  logic              rd_valid_q2;
  logic [DATA_W-1:0] rd_data_q2;

  assign clr_acc = clr_req && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q2 <= 1'b0;
      rd_data_q2  <= '0;
    end else if (clr_acc) begin
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q2 <= 1'b0;
      rd_data_q2  <= '0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q2 <= rd_valid_q;
      rd_data_q2  <= rd_data_q;
    end
  end

  assign rd_valid = rd_valid_q2;
  assign rd_data  = rd_data_q2;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Self-checking bench for ram_dp_be: directed spec scenarios plus randomized traffic against a byte-array model.
module tb_ram_dp_be;

`ifdef RAM_DP_BE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        clr_req, wr_en, rd_en;
  logic [3:0]  wr_be;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic        busy, rd_valid;
  logic [31:0] rd_data;

  logic        b_clr_req, b_wr_en, b_rd_en;
  logic [3:0]  b_wr_be;
  logic [4:0]  b_wr_addr, b_rd_addr;
  logic [31:0] b_wr_data;
  logic        b_busy, b_rd_valid;
  logic [31:0] b_rd_data;

  int n_tests;
  int n_fail;

  logic [7:0]  mdl [32][4];
  logic [32:0] expq [$];

  ram_dp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  ram_dp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .clr_req(b_clr_req), .busy(b_busy),
    .wr_en(b_wr_en), .wr_be(b_wr_be), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mdl_word(input int a);
    return {mdl[a][3], mdl[a][2], mdl[a][1], mdl[a][0]};
  endfunction

  task automatic mdl_write(input int a, input logic [3:0] be, input logic [31:0] d);
    if (a < 32) begin
      for (int k = 0; k < 4; k++) if (be[k]) mdl[a][k] = d[8*k +: 8];
    end
  endtask

  task automatic mdl_clear();
    for (int a = 0; a < 32; a++)
      for (int k = 0; k < 4; k++) mdl[a][k] = 8'h00;
  endtask

  task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_be = be; wr_data = d;
    mdl_write(a, be, d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_expect(input string tag, input int a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = 5'(a);
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      n++;
      tick();
    end
  endtask

  task automatic sync_q();
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    repeat (LAT) tick();
    expq.delete();
    repeat (LAT - 1) expq.push_back('0);
  endtask

  task automatic run_cycle(input string tag);
    logic [32:0] e;
    if (wr_en) mdl_write(int'(wr_addr), wr_be, wr_data);
    e = {rd_en, rd_en ? mdl_word(int'(rd_addr)) : 32'h0};
    expq.push_back(e);
    tick();
    e = expq.pop_front();
    chk({tag, "_valid"}, 32'(rd_valid), 32'(e[32]));
    chk({tag, "_data"}, rd_data, e[31:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d32, d20, nb;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0;
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_be = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    b_clr_req = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_be = '0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0;
    mdl_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'h0);

    // Initial clear after reset release: 32 cycles (20 for the small instance).
    rst_n = 1'b1;
    d32 = -1; d20 = -1;
    for (int c = 1; c <= 100 && (d32 < 0 || d20 < 0); c++) begin
      tick();
      if (d32 < 0 && !busy) d32 = c;
      if (d20 < 0 && !b_busy) d20 = c;
    end
    chk("init_clr_cycles32", 32'(d32), 32'd32);
    chk("init_clr_cycles20", 32'(d20), 32'd20);

    for (int a = 0; a < 32; a++) rd_expect("init_rd", a, 32'h0);

    // Byte-enable merge.
    wr(3, 4'b1111, 32'hDEADBEEF);
    wr(3, 4'b0101, 32'h11223344);
    rd_expect("be_merge", 3, 32'hDE22BE44);
    wr(3, 4'b0000, 32'h99999999);
    rd_expect("be_zero_noop", 3, 32'hDE22BE44);

    // Read-during-write, full and partial enables.
    wr_en = 1'b1; wr_addr = 5'd7; wr_be = 4'b1111; wr_data = 32'hCAFEF00D;
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("rdw_full_valid", 32'(rd_valid), 32'd1);
    chk("rdw_full_data", rd_data, 32'hCAFEF00D);
    wr_en = 1'b1; wr_addr = 5'd7; wr_be = 4'b0011; wr_data = 32'h12345678;
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("rdw_part_data", rd_data, 32'hCAFE5678);
    mdl_write(7, 4'b1111, 32'hCAFE5678);

    // Idle cycle after a read drops rd_valid and rd_data.
    repeat (LAT) tick();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_data", rd_data, 32'h0);

    // Randomized traffic against the model.
    sync_q();
    for (int i = 0; i < 300; i++) begin
      wr_en   = 1'($urandom);
      wr_be   = 4'($urandom);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      rd_en   = 1'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      run_cycle("rnd");
    end
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) run_cycle("rnd_drain");

    // Out-of-range access on the 20-word instance.
    b_wr_en = 1'b1; b_wr_addr = 5'd25; b_wr_be = 4'b1111; b_wr_data = 32'hFFFFFFFF;
    tick();
    b_wr_addr = 5'd19; b_wr_data = 32'hA5A5A5A5;
    tick();
    b_wr_en = 1'b0;
    foreach (b_wr_be[i]) begin end
    for (int j = 0; j < 3; j++) begin
      logic [4:0]  ra;
      logic [31:0] ex;
      ra = (j == 0) ? 5'd25 : (j == 1) ? 5'd5 : 5'd19;
      ex = (j == 2) ? 32'hA5A5A5A5 : 32'h0;
      b_rd_en = 1'b1; b_rd_addr = ra;
      tick();
      b_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      chk($sformatf("d20_rd%0d_valid", ra), 32'(b_rd_valid), 32'd1);
      chk($sformatf("d20_rd%0d_data", ra), b_rd_data, ex);
    end

    // Fill, then clear on request; a write during busy must be ignored.
    for (int a = 0; a < 32; a++) wr(a, 4'b1111, 32'(a));
    rd_expect("fill_rd31", 31, 32'd31);
    rd_expect("fill_rd9", 9, 32'd9);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd9;
    nb = 0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      nb++;
      chk("clr_rd_ignored", 32'(rd_valid), 32'd0);
      wr_en = (nb == 20); wr_addr = 5'd9; wr_be = 4'b1111; wr_data = 32'hFFFFFFFF;
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("req_clr_cycles", 32'(nb), 32'd32);
    mdl_clear();
    for (int a = 0; a < 32; a++) rd_expect("post_clr_rd", a, 32'h0);

    // Reset aborts a pending read.
    wr(4, 4'b1111, 32'h00005A5A);
    rd_en = 1'b1; rd_addr = 5'd4;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_rd_data", rd_data, 32'h0);
    #1;
    rst_n = 1'b1;
    measure_busy(nb);
    chk("abort_rd_clr_cycles", 32'(nb), 32'd32);

    // Reset at clear cycle 10 restarts the full clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midclr_busy", 32'(busy), 32'd1);
    chk("midclr_valid", 32'(rd_valid), 32'd0);
    chk("midclr_data", rd_data, 32'h0);
    #1;
    rst_n = 1'b1;
    measure_busy(nb);
    chk("midclr_restart_cycles", 32'(nb), 32'd32);
    mdl_clear();
    rd_expect("midclr_rd4", 4, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
